// File: rtl/mm_mem_arbiter_pkg.sv
// Shared definitions for the MM-stage data-memory arbiter.
// Provides the data width and the 2-bit FSM state encodings as macros.
// The macros are guarded, so an earlier project-wide definition takes precedence.
// The package carries the state enum and a wrap-around increment helper.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef MEM_ARB_IDLE
`define MEM_ARB_IDLE    2'd0
`endif
`ifndef MEM_ARB_ISSUE
`define MEM_ARB_ISSUE   2'd1
`endif
`ifndef MEM_ARB_WAIT_RD
`define MEM_ARB_WAIT_RD 2'd2
`endif

package mm_mem_arbiter_pkg;

  localparam int DATA_W = `DATA_W;

  typedef enum logic [1:0] {
    ARB_IDLE    = `MEM_ARB_IDLE,
    ARB_ISSUE   = `MEM_ARB_ISSUE,
    ARB_WAIT_RD = `MEM_ARB_WAIT_RD
  } arb_state_e;

  // (idx + 1) mod n, for idx already in [0, n-1]
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mm_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req   [N]     request vector
//   ptr   [IDX_W] index with highest priority; the search runs upward from ptr and wraps
//   valid         at least one request is set
//   idx   [IDX_W] winning index (0 when valid is low)
// Reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin : p_pick
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    // Walk from farthest to nearest so the nearest candidate at or after ptr is the last writer.
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mm_mem_arbiter.sv
// mm_mem_arbiter: round-robin arbiter that shares one single-port data memory
// between the MM stages of N_CORES pipeline cores. Only one transaction is
// outstanding at a time.
// Ports:
//   clk, rst (sync, active-high), en (gates new grants only)
//   core_req/core_we [N], core_addr [N*ADDR_W], core_wdata [N*DATA_W]  per-core requests
//   core_stall [N], core_ack [N] (one-hot pulse), core_rdata          per-core responses
//   mem_req/mem_we/mem_addr/mem_wdata (registered), mem_gnt, mem_rvalid, mem_rdata
//
// state   | meaning
// IDLE    | no transaction; on en & any request, latch the round-robin winner
// ISSUE   | mem_req held with stable fields until mem_gnt
// WAIT_RD | read granted; wait for mem_rvalid
`ifndef DATA_W
`define DATA_W 32
`endif

module mm_mem_arbiter
  import mm_mem_arbiter_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = `DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_stall,
  output logic [N_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]         core_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = $clog2(N_CORES);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_wr_done;
  logic               w_rd_done;
  logic [IDX_W-1:0]   w_ptr_next;

  rr_pick #(.N(N_CORES), .IDX_W(IDX_W)) u_rr_pick (
    .req   (core_req),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // Fields of the current round-robin candidate
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_we    = core_we[i];
        w_sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Completion is combinational so a write acks in the same cycle mem_gnt is seen
  assign w_wr_done = (r_state == ARB_ISSUE) && mem_gnt && r_mem_we;
  assign w_rd_done = (r_state == ARB_WAIT_RD) && mem_rvalid;
  assign w_ptr_next = IDX_W'(rr_next(int'(r_gnt_idx), N_CORES));

  always_comb begin
    core_ack = '0;
    if (w_wr_done || w_rd_done) core_ack[r_gnt_idx] = 1'b1;
  end

  assign core_rdata = w_rd_done ? mem_rdata : '0;
  assign core_stall = core_req & ~core_ack;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (en && w_pick_valid) begin
            r_gnt_idx   <= w_pick_idx;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_req   <= 1'b1;
            r_state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_rr_ptr <= w_ptr_next;
              r_state  <= ARB_IDLE;
            end else begin
              r_state  <= ARB_WAIT_RD;
            end
          end
        end
        ARB_WAIT_RD: begin
          if (mem_rvalid) begin
            r_rr_ptr <= w_ptr_next;
            r_state  <= ARB_IDLE;
          end
        end
        default: begin
          r_state   <= ARB_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_mem_arbiter.sv
`ifndef DATA_W
`define DATA_W 32
`endif

module tb_mm_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N-1:0]    core_req, core_we;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_stall, core_ack;
  logic [DW-1:0]   core_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt, mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  // Reference record of each core's pending request and the round-robin pointer
  logic          m_we   [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int            model_ptr;

  always #5 clk = ~clk;

  mm_mem_arbiter #(.N_CORES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_we[i] = we; m_addr[i] = a; m_data[i] = d;
    core_we[i] = we;
    core_addr[i*AW +: AW] = a;
    core_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  function automatic int model_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w, d;
    logic [DW-1:0] rd;
    logic [AW-1:0] a0;

    // ---------------- reset values ----------------
    do_reset();
    en = 1'b0;
    core_req = 4'b0101;
    settle();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ack", core_ack, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_stall", core_stall, 4'b0101);
    next_cycle();
    settle();
    check("en_low_no_req", mem_req, 0);
    core_req = '0; en = 1'b1;

    // ---------------- single write ----------------
    next_cycle();
    set_core(1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    core_req = 4'b0010; mem_gnt = 1'b1;
    settle();
    check("wr_T_stall", core_stall, 4'b0010);
    check("wr_T_mem_req", mem_req, 0);
    next_cycle(); settle();
    check("wr_T1_mem_req", mem_req, 1);
    check("wr_T1_addr", mem_addr, 32'h40);
    check("wr_T1_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_T1_we", mem_we, 1);
    check("wr_T1_ack", core_ack, 4'b0010);
    check("wr_T1_stall", core_stall, 4'b0000);
    next_cycle();
    core_req = '0; mem_gnt = 1'b0;
    settle();
    check("wr_T2_ack", core_ack, 0);
    check("wr_T2_mem_req", mem_req, 0);
    model_ptr = 2;

    // ---------------- single read ----------------
    set_core(2, 1'b0, 32'h80, 32'h0);
    core_req = 4'b0100;
    settle();
    check("rd_T_stall", core_stall, 4'b0100);
    next_cycle();
    mem_gnt = 1'b1;
    settle();
    check("rd_T1_mem_req", mem_req, 1);
    check("rd_T1_addr", mem_addr, 32'h80);
    check("rd_T1_we", mem_we, 0);
    check("rd_T1_ack", core_ack, 0);
    check("rd_T1_stall", core_stall, 4'b0100);
    next_cycle();
    mem_gnt = 1'b0;
    settle();
    check("rd_T2_mem_req", mem_req, 0);
    check("rd_T2_ack", core_ack, 0);
    check("rd_T2_stall", core_stall, 4'b0100);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    settle();
    check("rd_T3_ack", core_ack, 4'b0100);
    check("rd_T3_rdata", core_rdata, 32'h1234);
    check("rd_T3_stall", core_stall, 4'b0000);
    next_cycle();
    mem_rvalid = 1'b0; core_req = '0;
    settle();
    check("rd_T4_rdata", core_rdata, 0);

    // ---------------- fairness ----------------
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, AW'(i * 16), DW'(32'hF000 + i));
    core_req = 4'b1111; mem_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle(); settle();
      check("fair_ack", core_ack, 64'(1) << (k % N));
      check("fair_addr", mem_addr, (k % N) * 16);
      next_cycle(); settle();
      check("fair_gap", core_ack, 0);
    end
    core_req = '0; mem_gnt = 1'b0;
    model_ptr = 1;

    // ---------------- backpressure ----------------
    next_cycle();
    set_core(3, 1'b1, 32'h3C, 32'hCAFE_0003);
    core_req = 4'b1000;
    next_cycle();
    for (int j = 0; j < 5; j++) begin
      settle();
      check("bp_mem_req", mem_req, 1);
      check("bp_addr", mem_addr, 32'h3C);
      check("bp_wdata", mem_wdata, 32'hCAFE_0003);
      check("bp_ack", core_ack, 0);
      next_cycle();
    end
    mem_gnt = 1'b1;
    settle();
    check("bp_ack_final", core_ack, 4'b1000);
    next_cycle();
    mem_gnt = 1'b0; core_req = '0;
    model_ptr = 0;

    // ---------------- en low, then en dropped during WAIT_RD ----------------
    en = 1'b0;
    set_core(0, 1'b0, 32'h100, 32'h0);
    core_req = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      next_cycle(); settle();
      check("en_low_mem_req", mem_req, 0);
    end
    en = 1'b1;
    next_cycle(); settle();
    check("en_hi_mem_req", mem_req, 1);
    check("en_hi_addr", mem_addr, 32'h100);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0; en = 1'b0;
    settle();
    check("en_wait_ack", core_ack, 0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5;
    settle();
    check("en_drop_ack", core_ack, 4'b0001);
    check("en_drop_rdata", core_rdata, 32'hA5A5);
    next_cycle();
    mem_rvalid = 1'b0; core_req = '0; en = 1'b1;
    model_ptr = 1;

    // ---------------- reset during WAIT_RD ----------------
    set_core(1, 1'b0, 32'h44, 32'h0);
    core_req = 4'b0010;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0; rst = 1'b1; core_req = '0;
    next_cycle();
    rst = 1'b0;
    settle();
    check("rrst_mem_req", mem_req, 0);
    check("rrst_ack", core_ack, 0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    settle();
    check("rrst_stray_ack", core_ack, 0);
    check("rrst_stray_rdata", core_rdata, 0);
    check("rrst_idle", mem_req, 0);
    next_cycle();
    mem_rvalid = 1'b0;
    for (int i = 0; i < N; i++) set_core(i, 1'b0, AW'(32'h200 + i * 4), 32'h0);
    core_req = 4'b1111;
    next_cycle(); settle();
    check("rrst_winner_req", mem_req, 1);
    check("rrst_winner_addr", mem_addr, 32'h200);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    settle();
    check("rrst_winner_ack", core_ack, 4'b0001);
    next_cycle();
    mem_rvalid = 1'b0; core_req = '0;
    model_ptr = 1;

    // ---------------- randomized traffic vs. transaction-level model ----------------
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!core_req[i] && $urandom_range(0, 1) == 1) begin
          set_core(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          core_req[i] = 1'b1;
        end
      if (core_req == '0) begin
        w = $urandom_range(0, N - 1);
        set_core(w, 1'($urandom_range(0, 1)), $urandom, $urandom);
        core_req[w] = 1'b1;
      end
      w = model_winner(core_req, model_ptr);
      mem_rdata = $urandom;
      settle();
      check("rnd_idle_stall", core_stall, core_req);
      check("rnd_idle_ack", core_ack, 0);
      next_cycle();
      // Winner sometimes withdraws after being latched; the transaction still completes
      if ($urandom_range(0, 3) == 0) core_req[w] = 1'b0;
      settle();
      check("rnd_mem_req", mem_req, 1);
      check("rnd_mem_we", mem_we, m_we[w]);
      check("rnd_mem_addr", mem_addr, m_addr[w]);
      check("rnd_mem_wdata", mem_wdata, m_data[w]);
      d = $urandom_range(0, 3);
      for (int j = 0; j < d; j++) begin
        mem_rvalid = 1'($urandom_range(0, 1));
        settle();
        check("rnd_bp_ack", core_ack, 0);
        check("rnd_bp_rdata", core_rdata, 0);
        check("rnd_bp_addr", mem_addr, m_addr[w]);
        next_cycle();
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      settle();
      if (m_we[w]) begin
        check("rnd_wr_ack", core_ack, 64'(1) << w);
        check("rnd_wr_stall", core_stall, core_req & ~(N'(1) << w));
      end else begin
        check("rnd_rd_gnt_ack", core_ack, 0);
        next_cycle();
        d = $urandom_range(0, 3);
        for (int j = 0; j < d; j++) begin
          mem_gnt = 1'($urandom_range(0, 1));
          settle();
          check("rnd_rd_wait_ack", core_ack, 0);
          check("rnd_rd_wait_req", mem_req, 0);
          next_cycle();
        end
        mem_gnt = 1'b0;
        rd = $urandom;
        mem_rvalid = 1'b1; mem_rdata = rd;
        settle();
        check("rnd_rd_ack", core_ack, 64'(1) << w);
        check("rnd_rd_rdata", core_rdata, rd);
        check("rnd_rd_stall", core_stall, core_req & ~(N'(1) << w));
      end
      next_cycle();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      core_req[w] = 1'b0;
      model_ptr = (w + 1) % N;
    end

    a0 = mem_addr;
    core_req = '0;
    next_cycle(); settle();
    check("end_idle_req", mem_req, 0);
    check("end_fields_hold", mem_addr, a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
